// File: rtl/gate_truth_table_sequencer.sv
// Truth-table sequencer for the logic-gate demo board.
// Walks {A,B} through 00,01,10,11 on a debounced button (manual) or a fixed
// tick (auto), shows the selected gate function of A,B and flags a full table.
module gate_truth_table_sequencer #(
  parameter int STEP_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       I_P_CLK,
  input  logic       I_P_RST_N,
  input  logic       I_P_BTN_STEP,
  input  logic       I_P_AUTO,
  input  logic [2:0] I_P_GATE_SEL,
  output logic       O_P_LED_A,
  output logic       O_P_LED_B,
  output logic       O_P_LED_GATE,
  output logic [2:0] O_P_LED_SEL,
  output logic       O_P_LED_DONE
);

  localparam int TICK_W = $clog2(STEP_CYCLES);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_FULL   = DB_W'(DEBOUNCE_CYCLES);

  // {btn, auto, sel[2:0]} through two flops each
  logic [4:0] sync1, sync2;
  logic       btn_s, auto_s;
  logic [2:0] sel_s;

  logic [DB_W-1:0]   db_cnt;
  logic              db_lvl, db_lvl_q, step;

  logic [1:0]        row, row_nx;
  logic [TICK_W-1:0] tick, tick_nx;
  logic [2:0]        sel_q, sel_nx;
  logic              auto_q;
  logic              done, done_nx;
  logic              gate, gate_nx;
  logic              adv;

  assign btn_s  = sync2[4];
  assign auto_s = sync2[3];
  assign sel_s  = sync2[2:0];

  // Two-stage synchronizers for all raw board inputs
  always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
    if (!I_P_RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {I_P_BTN_STEP, I_P_AUTO, I_P_GATE_SEL};
      sync2 <= sync1;
    end
  end

  // Debounce: level rises only after the button is stable high for the full
  // count; any low sample restarts it, so a held button yields one edge.
  always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
    if (!I_P_RST_N) begin
      db_cnt   <= '0;
      db_lvl   <= 1'b0;
      db_lvl_q <= 1'b0;
    end else begin
      db_lvl_q <= db_lvl;
      if (!btn_s) begin
        db_cnt <= '0;
        db_lvl <= 1'b0;
      end else if (db_cnt == DB_FULL) begin
        db_lvl <= 1'b1;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign step = db_lvl & ~db_lvl_q;

  // Next row/tick/done/sel; a select change overrides any advance this cycle.
  // Gate is computed from the next row and sel so all LEDs move together.
  always_comb begin
    row_nx  = row;
    tick_nx = tick;
    done_nx = done;
    sel_nx  = sel_q;
    adv     = 1'b0;
    gate_nx = 1'b0;

    if (auto_s != auto_q) begin
      tick_nx = '0;
    end else if (auto_s) begin
      if (tick == TICK_LAST) begin
        tick_nx = '0;
        adv     = 1'b1;
      end else begin
        tick_nx = tick + TICK_W'(1);
      end
    end else begin
      tick_nx = '0;
      adv     = step;
    end

    if (adv) begin
      row_nx = row + 2'd1;
      if (row == 2'b11) done_nx = 1'b1;
    end

    if (sel_s != sel_q) begin
      sel_nx  = sel_s;
      row_nx  = 2'b00;
      tick_nx = '0;
      done_nx = 1'b0;
    end

    case (sel_nx)
      3'b000:  gate_nx =   row_nx[1] & row_nx[0];
      3'b001:  gate_nx =   row_nx[1] | row_nx[0];
      3'b010:  gate_nx =   row_nx[1] ^ row_nx[0];
      3'b011:  gate_nx = ~(row_nx[1] ^ row_nx[0]);
      3'b100:  gate_nx = ~(row_nx[1] & row_nx[0]);
      3'b101:  gate_nx = ~(row_nx[1] | row_nx[0]);
      3'b110:  gate_nx =  ~row_nx[1];
      default: gate_nx =   row_nx[1];
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
    if (!I_P_RST_N) begin
      row    <= 2'b00;
      tick   <= '0;
      sel_q  <= 3'b000;
      auto_q <= 1'b0;
      done   <= 1'b0;
      gate   <= 1'b0;
    end else begin
      row    <= row_nx;
      tick   <= tick_nx;
      sel_q  <= sel_nx;
      auto_q <= auto_s;
      done   <= done_nx;
      gate   <= gate_nx;
    end
  end

  assign O_P_LED_A    = row[1];
  assign O_P_LED_B    = row[0];
  assign O_P_LED_GATE = gate;
  assign O_P_LED_SEL  = sel_q;
  assign O_P_LED_DONE = done;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Self-checking bench for gate_truth_table_sequencer (DEBOUNCE 4, STEP 8).
module tb_gate_truth_table_sequencer;
  localparam int D = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       auto_m = 1'b0;
  logic [2:0] sel = 3'b000;
  logic       a, b, g, done;
  logic [2:0] sel_o;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // truth-table column per gate, bit index = {A,B}
  logic [3:0] gate_tt [8];

  typedef struct {
    logic [2:0] sel;
    int         presses;
    logic [1:0] row;
    logic       gate;
    logic       done;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  gate_truth_table_sequencer #(.STEP_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .I_P_CLK(clk), .I_P_RST_N(rst_n), .I_P_BTN_STEP(btn), .I_P_AUTO(auto_m),
    .I_P_GATE_SEL(sel), .O_P_LED_A(a), .O_P_LED_B(b), .O_P_LED_GATE(g),
    .O_P_LED_SEL(sel_o), .O_P_LED_DONE(done));

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] r, input logic gt,
                           input logic dn, input logic [2:0] s);
    chk({tag, " row"},  {6'd0, a, b},  {6'd0, r});
    chk({tag, " gate"}, {7'd0, g},     {7'd0, gt});
    chk({tag, " done"}, {7'd0, done},  {7'd0, dn});
    chk({tag, " sel"},  {5'd0, sel_o}, {5'd0, s});
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int hold);
    btn = 1'b1;
    edges(hold);
    btn = 1'b0;
    edges(4);
  endtask

  // The gate LED must always match the shown row and select
  always @(negedge clk) begin
    if (mon_en) chk("gate invariant", {7'd0, g}, {7'd0, gate_tt[sel_o][{a, b}]});
  end

  initial begin
    logic [1:0] prev, r, exp_row;
    logic [2:0] cur;
    int steps, last, t, len, gap;
    bit wrapped, found;

    gate_tt[0] = 4'b1000; gate_tt[1] = 4'b1110; gate_tt[2] = 4'b0110; gate_tt[3] = 4'b1001;
    gate_tt[4] = 4'b0111; gate_tt[5] = 4'b0001; gate_tt[6] = 4'b0011; gate_tt[7] = 4'b1100;

    vecs[0] = '{3'b000, 3, 2'b11, 1'b1, 1'b0};
    vecs[1] = '{3'b001, 1, 2'b01, 1'b1, 1'b0};
    vecs[2] = '{3'b010, 2, 2'b10, 1'b1, 1'b0};
    vecs[3] = '{3'b100, 3, 2'b11, 1'b0, 1'b0};
    vecs[4] = '{3'b101, 0, 2'b00, 1'b1, 1'b0};
    vecs[5] = '{3'b110, 2, 2'b10, 1'b0, 1'b0};
    vecs[6] = '{3'b111, 5, 2'b01, 1'b0, 1'b1};
    vecs[7] = '{3'b011, 4, 2'b00, 1'b1, 1'b1};

    // reset with sel 011, manual
    sel = 3'b011;
    edges(3);
    check_out("in reset", 2'b00, 1'b0, 1'b0, 3'b000);
    rst_n = 1'b1;
    edges(2);
    chk("sel latency", {5'd0, sel_o}, 8'd0);
    edges(1);
    check_out("after reset", 2'b00, 1'b1, 1'b0, 3'b011);
    mon_en = 1'b1;

    // four clean presses, step lands on edge 7 after the press
    for (int i = 0; i < 4; i++) begin
      btn = 1'b1;
      edges(7);
      chk("press early", {6'd0, a, b}, {6'd0, 2'(i)});
      edges(1);
      check_out("press", 2'(i + 1), (i >= 2), (i == 3), 3'b011);
      edges(2);
      btn = 1'b0;
      edges(4);
    end

    // bounce shorter than debounce window -> no step
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; edges(2);
      btn = 1'b0; edges(2);
    end
    edges(10);
    check_out("bounce", 2'b00, 1'b1, 1'b1, 3'b011);
    btn = 1'b1; edges(5); btn = 1'b0; edges(10);
    check_out("short hold", 2'b01, 1'b0, 1'b1, 3'b011);

    // reset in the middle of a debounce aborts it
    btn = 1'b1;
    edges(3);
    #2 rst_n = 1'b0;
    btn = 1'b0;
    edges(2);
    rst_n = 1'b1;
    edges(12);
    check_out("reset mid debounce", 2'b00, 1'b1, 1'b0, 3'b011);

    // table-driven select + press vectors
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      edges(3);
      check_out("vec sel", 2'b00, gate_tt[vecs[i].sel][0], 1'b0, vecs[i].sel);
      for (int p = 0; p < vecs[i].presses; p++) press(10);
      check_out("vec end", vecs[i].row, vecs[i].gate, vecs[i].done, vecs[i].sel);
    end

    // randomized manual holds against a step-count model
    cur = 3'b011;
    steps = 0;
    for (int round = 0; round < 6; round++) begin
      sel = 3'($urandom_range(0, 7));
      if (sel != cur) begin
        cur = sel;
        steps = 0;
      end
      edges(3);
      for (int p = 0; p < int'($urandom_range(1, 6)); p++) begin
        len = int'($urandom_range(1, 10));
        gap = int'($urandom_range(2, 5));
        btn = 1'b1; edges(len);
        btn = 1'b0; edges(gap);
        if (len >= D + 1) steps++;
      end
      edges(12);
      exp_row = 2'(steps % 4);
      check_out("random", exp_row, gate_tt[cur][exp_row], (steps >= 4), cur);
    end

    // auto mode, sel 000
    sel = 3'b001; edges(3);
    sel = 3'b000; edges(3);
    check_out("auto start", 2'b00, 1'b0, 1'b0, 3'b000);
    auto_m = 1'b1;
    prev = 2'b00; last = -1; wrapped = 1'b0; found = 1'b0;
    for (t = 1; t <= 80; t++) begin
      if (t == 20) btn = 1'b1;
      if (t == 32) btn = 1'b0;
      edges(1);
      r = {a, b};
      if (r != prev) begin
        chk("auto order", {6'd0, r}, {6'd0, prev + 2'd1});
        if (last < 0) begin
          checks++;
          if (t != S + 2 && t != S + 3) begin
            errors++;
            $display("FAIL auto first advance got %0d expected %0d", t, S + 3);
          end
        end else begin
          chk_int("auto interval", t - last, S);
        end
        if (prev == 2'b11) wrapped = 1'b1;
        last = t;
        prev = r;
      end
      chk("auto done", {7'd0, done}, {7'd0, wrapped});
      if (wrapped && r == 2'b10) begin
        found = 1'b1;
        break;
      end
    end
    chk("auto reach row10", {7'd0, found}, 8'd1);

    // select change at row 10 with done set
    sel = 3'b101;
    edges(2);
    check_out("pre sel change", 2'b10, 1'b0, 1'b1, 3'b000);
    edges(1);
    check_out("sel change", 2'b00, 1'b1, 1'b0, 3'b101);
    edges(7);
    chk("tick restart hold", {6'd0, a, b}, 8'd0);
    edges(1);
    check_out("tick restart adv", 2'b01, 1'b0, 1'b0, 3'b101);

    // async reset at row 11
    for (int i = 0; i < 20 && {a, b} != 2'b11; i++) edges(1);
    chk("reach row11", {6'd0, a, b}, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    check_out("async reset", 2'b00, 1'b0, 1'b0, 3'b000);
    auto_m = 1'b0;
    edges(2);
    rst_n = 1'b1;
    edges(3);
    check_out("after async reset", 2'b00, 1'b1, 1'b0, 3'b101);
    auto_m = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3 * S; i++) begin
      edges(1);
      if ({a, b} != 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    chk("restart row", {6'd0, a, b}, 8'd1);
    chk("restart seen", {7'd0, found}, 8'd1);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_sequencer.md
# gate_truth_table_sequencer

Board-level controller that sequences the two operand inputs of the logic-gate demonstration datapath through all four truth-table rows and selects which gate function is shown on the result LED. It replaces the raw operand switches with a debounced step button (manual mode) or a fixed-rate timer (auto mode), and lights a done LED once a full truth table has been shown for the current gate. It sits between the BASYS 3 switches/button and the LED outputs.

## Interface

- STEP_CYCLES, 50_000_000: clock cycles per row in auto mode (0.5 s at 100 MHz); minimum 2.
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronized button must be stable high to count as a press; minimum 1.

- I_P_CLK  input  1  100 MHz board clock; all state on rising edge.
- I_P_RST_N  input  1  asynchronous, active-low reset; the only reset.
- I_P_BTN_STEP  input  1  raw step button, asynchronous, bouncy.
- I_P_AUTO  input  1  raw mode switch: 1 = auto, 0 = manual.
- I_P_GATE_SEL  input  3  raw gate-select switches.
- O_P_LED_A  output  1  current operand A (row bit 1).
- O_P_LED_B  output  1  current operand B (row bit 0).
- O_P_LED_GATE  output  1  selected gate function of A, B.
- O_P_LED_SEL  output  3  synchronized gate select echo.
- O_P_LED_DONE  output  1  all four rows shown for current gate.

## Operation

- Synchronizers: I_P_BTN_STEP, I_P_AUTO and each I_P_GATE_SEL bit pass through 2-flop synchronizers (reset 0) before any use.
- Debounce: counter increments while synced button is 1, clears to 0 when it is 0; debounced level goes 1 when counter reaches DEBOUNCE_CYCLES, 0 when synced button is 0. Step pulse = one-cycle rising edge of debounced level. Holding the button gives exactly one step.
- Row counter ROW[1:0] = {A,B}; advance order 00, 01, 10, 11, 00 (wrap).
- Manual mode (synced AUTO = 0): ROW advances by 1 per step pulse; tick counter held at 0.
- Auto mode (synced AUTO = 1): tick counter counts 0..STEP_CYCLES-1; at STEP_CYCLES-1 ROW advances and counter returns to 0. Step pulses ignored.
- Mode change: tick counter cleared to 0; ROW and DONE hold.
- Gate functions on sel: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT A, 111 A (buffer).
- Select change (synced sel differs from registered sel): registered sel updates, ROW forced to 00, tick counter cleared, DONE cleared; any advance in that same cycle is discarded.
- DONE: set on the advance 11 -> 00; stays set (further wraps keep it 1) until select change or reset.

## Timing

- Reset (async assert, sync release): ROW = 00, registered sel = 000, tick/debounce counters = 0, debounced level = 0; all outputs 0 (O_P_LED_GATE = AND(0,0) = 0).
- All outputs registered. O_P_LED_GATE is computed from next ROW and next sel, so A, B, GATE and SEL change on the same edge; no cycle shows a stale gate value.
- Manual latency: raw button rises before edge 0 and stays high -> step pulse high during cycle 2+DEBOUNCE_CYCLES -> A/B/GATE update at edge 3+DEBOUNCE_CYCLES.
- Auto: first advance STEP_CYCLES cycles after entering auto (after sync), then every STEP_CYCLES cycles exactly.
- Select latency: raw switch change -> outputs show ROW 00 with new gate 3 edges later (2 sync + 1 register).
- Bounce shorter than DEBOUNCE_CYCLES produces no step. Reset asserted mid-debounce or mid-tick aborts; no step after release unless the button is re-held a full DEBOUNCE_CYCLES.

## Test plan

Use DEBOUNCE_CYCLES = 4, STEP_CYCLES = 8.
- Reset with sel = 011, AUTO = 0 -> all outputs 0 during reset; 3 edges after release SEL = 011, A = 0, B = 0, GATE = 1, DONE = 0.
- Manual, sel = 011: four clean presses (held 10 cycles each) -> rows 01/0, 10/0, 11/1, 00/1 for {AB}/GATE; DONE = 1 at the fourth step, same edge as row 00; each step at edge 7 after press.
- Bounce: button toggles every 2 cycles for 20 cycles then releases -> ROW unchanged; one 5-cycle hold -> exactly one step.
- Auto, sel = 000: ROW advances every 8 cycles; GATE = 1 only at row 11; DONE sets at first 11 -> 00 wrap; presses during auto -> no extra step.
- Select change at row 10 with DONE = 1, sel 000 -> 101 -> ROW = 00, GATE = 1 (NOR), DONE = 0, tick restarts (next advance 8 cycles later).
- Async reset asserted mid-auto at row 11 -> outputs 0 immediately, no wait for clock; after release sequence restarts at row 00.
